// File: rtl/btn_reader_pkg.sv
// btn_reader_pkg: shared constants for the pushbutton reader.
//   RD_W       : read data bus width
//   ADDR_STATE : debounced level register
//   ADDR_RISE  : sticky rise flags (clear-on-read)
//   ADDR_FALL  : sticky fall flags (clear-on-read)
//   ADDR_INFO  : number of inputs (constant)
package btn_reader_pkg;

    localparam int unsigned RD_W = 32;

    localparam logic [1:0] ADDR_STATE = 2'd0;
    localparam logic [1:0] ADDR_RISE  = 2'd1;
    localparam logic [1:0] ADDR_FALL  = 2'd2;
    localparam logic [1:0] ADDR_INFO  = 2'd3;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one-bit synchroniser + debouncer.
// Ports:
//   clk      : system clock
//   resetn   : asynchronous active-low reset
//   i_btn    : raw asynchronous pad input
//   o_stable : debounced level
//   o_rise   : one-cycle pulse, asserted on the edge where o_stable goes 0->1
//   o_fall   : one-cycle pulse, asserted on the edge where o_stable goes 1->0
// The pulses are combinational from registered state, so a flag register
// sampling them updates on the same edge as o_stable.
module btn_debounce
    import btn_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_btn,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_terminal;

    assign w_differ   = r_sync ^ r_stable;
    assign w_terminal = w_differ && (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_terminal) begin
                // Accept the new level; counter restarts so it never wraps.
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = w_terminal & r_sync;
    assign o_fall   = w_terminal & ~r_sync;

endmodule

// File: rtl/btn_reader.sv
// btn_reader: WIDTH debounced pushbutton inputs with sticky edge flags and a
// registered polled read port.
// Ports:
//   clk       : system clock
//   resetn    : asynchronous active-low reset
//   btn_in    : raw asynchronous pad inputs [WIDTH]
//   rd_en     : read strobe (one cycle per access)
//   rd_addr   : register select (0 state, 1 rise, 2 fall, 3 WIDTH)
//   rd_data   : read data, valid while rd_ack=1, holds otherwise
//   rd_ack    : pulses the cycle after rd_en
//   btn_state : debounced levels
//   irq       : (only with BTN_READER_IRQ_EN) registered OR of all flags
// Optional build macro: BTN_READER_IRQ_EN.
module btn_reader
    import btn_reader_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [WIDTH-1:0]  btn_in,
    input  logic              rd_en,
    input  logic [1:0]        rd_addr,
    output logic [RD_W-1:0]   rd_data,
    output logic              rd_ack,
`ifdef BTN_READER_IRQ_EN
    output logic              irq,
`endif
    output logic [WIDTH-1:0]  btn_state
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [RD_W-1:0]  r_rd_data;
    logic             r_rd_ack;
    logic             w_clr_rise;
    logic             w_clr_fall;
    logic [RD_W-1:0]  w_rd_mux;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .resetn   (resetn),
            .i_btn    (btn_in[g]),
            .o_stable (w_stable[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g])
        );
    end

    assign w_clr_rise = rd_en && (rd_addr == ADDR_RISE);
    assign w_clr_fall = rd_en && (rd_addr == ADDR_FALL);

    always_comb begin
        w_rd_mux = '0;
        case (rd_addr)
            ADDR_STATE: w_rd_mux = RD_W'(w_stable);
            ADDR_RISE:  w_rd_mux = RD_W'(r_rise);
            ADDR_FALL:  w_rd_mux = RD_W'(r_fall);
            ADDR_INFO:  w_rd_mux = RD_W'(WIDTH);
            default:    w_rd_mux = '0;
        endcase
    end

    // Clear is applied before OR-ing in new events, so an event landing on
    // the clearing edge survives while rd_data captures the pre-event value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rise    <= '0;
            r_fall    <= '0;
            r_rd_data <= '0;
            r_rd_ack  <= 1'b0;
        end else begin
            r_rise   <= (r_rise & ~{WIDTH{w_clr_rise}}) | w_rise;
            r_fall   <= (r_fall & ~{WIDTH{w_clr_fall}}) | w_fall;
            r_rd_ack <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

`ifdef BTN_READER_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_rise | r_fall);
        end
    end

    assign irq = r_irq;
`endif

    assign rd_data   = r_rd_data;
    assign rd_ack    = r_rd_ack;
    assign btn_state = w_stable;

endmodule
